// File: rtl/uart_pkt_rx.sv
// uart_pkt_rx: 8N1 UART receiver feeding a framed-write parser (A5, CMD, ADDR, LEN, payload).
// Latency: each payload word is presented on wr_* the cycle after its last byte completes.
// Backpressure: one word is held on wr_valid/wr_ready; a second word completing first is an overrun error.
// Define UART_PKT_CHKSUM_EN to expect a trailing XOR checksum byte (CMD..last payload byte).
module uart_pkt_rx #(
    parameter int CLK_HZ       = 50_000_000,
    parameter int BAUD         = 115_200,
    parameter int WORD_BYTES   = 4,
    parameter int ADDR_W       = 16,
    parameter int TIMEOUT_CLKS = 100_000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    uart_rx,
    output logic                    wr_valid,
    input  logic                    wr_ready,
    output logic [1:0]              wr_tgt,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [8*WORD_BYTES-1:0] wr_data,
    output logic                    frame_done,
    output logic                    err_valid,
    output logic [2:0]              err_code,
    output logic                    busy
);
    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int ADDR_BYTES   = (ADDR_W + 7) / 8;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam int TO_W         = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CNT_W-1:0] HALF_BIT  = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CLKS - 1);
    localparam logic [7:0]       ADDR_LAST = 8'(ADDR_BYTES - 1);
    localparam logic [7:0]       WORD_LAST = 8'(WORD_BYTES - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {IDLE, CMD, ADDR, LEN, DATA
`ifdef UART_PKT_CHKSUM_EN
        , CHK
`endif
    } state_t;

    logic rx_meta, rx_sync, rx_prev;
    rx_state_t rx_state;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0] rx_bit;
    logic [7:0] rx_shift;
    logic byte_vld, byte_ferr;

    state_t state;
    logic [1:0] tgt_r;
    logic [7:0] idx, len_left;
    logic [8*ADDR_BYTES-1:0] addr_acc, addr_nxt;
    logic [8*WORD_BYTES-1:0] word_buf, word_nxt;
    logic [ADDR_W-1:0] nxt_addr;
    logic fin;
    logic [TO_W-1:0] tcnt;
    logic hs;
`ifdef UART_PKT_CHKSUM_EN
    logic [7:0] chk;
`endif

    assign hs   = wr_valid && wr_ready;
    assign busy = (state != IDLE);

    // Two-flop synchroniser plus one delayed copy for start-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Bit-level receiver: mid-bit sampling; emits a byte pulse or a framing-error pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state  <= RX_IDLE;
            rx_cnt    <= '0;
            rx_bit    <= '0;
            rx_shift  <= '0;
            byte_vld  <= 1'b0;
            byte_ferr <= 1'b0;
        end else begin
            byte_vld  <= 1'b0;
            byte_ferr <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        rx_state <= RX_START;
                        rx_cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (rx_cnt == HALF_BIT) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == LAST_BIT) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        rx_bit   <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == LAST_BIT) begin
                        rx_state <= RX_IDLE;
                        if (rx_sync) byte_vld  <= 1'b1;
                        else         byte_ferr <= 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // Merge the incoming byte into the address / word being assembled
    always_comb begin
        addr_nxt = addr_acc;
        word_nxt = word_buf;
        for (int i = 0; i < ADDR_BYTES; i++)
            if (idx == 8'(i)) addr_nxt[i*8 +: 8] = rx_shift;
        for (int i = 0; i < WORD_BYTES; i++)
            if (idx == 8'(i)) word_nxt[i*8 +: 8] = rx_shift;
    end

    // Frame parser: errors take priority over bytes, bytes over timeout, timeout over completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tgt_r      <= '0;
            idx        <= '0;
            len_left   <= '0;
            addr_acc   <= '0;
            word_buf   <= '0;
            nxt_addr   <= '0;
            fin        <= 1'b0;
            tcnt       <= '0;
            wr_valid   <= 1'b0;
            wr_tgt     <= '0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
            err_valid  <= 1'b0;
            err_code   <= '0;
`ifdef UART_PKT_CHKSUM_EN
            chk        <= '0;
`endif
        end else begin
            frame_done <= 1'b0;
            err_valid  <= 1'b0;
            if (hs) wr_valid <= 1'b0;
            if (state == IDLE || byte_vld) tcnt <= '0;
            else                           tcnt <= tcnt + 1'b1;

            if (byte_ferr) begin
                err_valid <= 1'b1; err_code <= 3'd1; state <= IDLE; fin <= 1'b0;
            end else if (byte_vld) begin
                case (state)
                    IDLE: if (rx_shift == 8'hA5) state <= CMD;
                    CMD: begin
                        if (rx_shift >= 8'h01 && rx_shift <= 8'h03) begin
                            tgt_r <= rx_shift[1:0] - 2'd1;
                            idx   <= '0;
                            state <= ADDR;
`ifdef UART_PKT_CHKSUM_EN
                            chk   <= rx_shift;
`endif
                        end else begin
                            err_valid <= 1'b1; err_code <= 3'd2; state <= IDLE; fin <= 1'b0;
                        end
                    end
                    ADDR: begin
                        addr_acc <= addr_nxt;
`ifdef UART_PKT_CHKSUM_EN
                        chk <= chk ^ rx_shift;
`endif
                        if (idx == ADDR_LAST) begin
                            nxt_addr <= addr_nxt[ADDR_W-1:0];
                            state    <= LEN;
                        end else begin
                            idx <= idx + 8'd1;
                        end
                    end
                    LEN: begin
`ifdef UART_PKT_CHKSUM_EN
                        chk <= chk ^ rx_shift;
`endif
                        if (rx_shift == 8'd0) begin
                            err_valid <= 1'b1; err_code <= 3'd3; state <= IDLE; fin <= 1'b0;
                        end else begin
                            len_left <= rx_shift;
                            idx      <= '0;
                            state    <= DATA;
                        end
                    end
                    DATA: begin
                        // Bytes after the last word (while waiting for its handshake) are ignored
                        if (!fin) begin
`ifdef UART_PKT_CHKSUM_EN
                            chk <= chk ^ rx_shift;
`endif
                            if (idx == WORD_LAST) begin
                                if (wr_valid && !wr_ready) begin
                                    wr_valid  <= 1'b0;
                                    err_valid <= 1'b1; err_code <= 3'd4; state <= IDLE; fin <= 1'b0;
                                end else begin
                                    wr_valid <= 1'b1;
                                    wr_data  <= word_nxt;
                                    wr_addr  <= nxt_addr;
                                    wr_tgt   <= tgt_r;
                                    nxt_addr <= nxt_addr + 1'b1;
                                    idx      <= '0;
                                    len_left <= len_left - 8'd1;
                                    if (len_left == 8'd1) begin
`ifdef UART_PKT_CHKSUM_EN
                                        state <= CHK;
`else
                                        fin   <= 1'b1;
`endif
                                    end
                                end
                            end else begin
                                word_buf <= word_nxt;
                                idx      <= idx + 8'd1;
                            end
                        end
                    end
`ifdef UART_PKT_CHKSUM_EN
                    CHK: begin
                        if (!fin) begin
                            if (rx_shift == chk) begin
                                fin <= 1'b1;
                            end else begin
                                err_valid <= 1'b1; err_code <= 3'd6; state <= IDLE; fin <= 1'b0;
                            end
                        end
                    end
`endif
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE && tcnt == TO_LAST) begin
                err_valid <= 1'b1; err_code <= 3'd5; state <= IDLE; fin <= 1'b0;
            end else if (fin && (!wr_valid || hs)) begin
                frame_done <= 1'b1;
                state      <= IDLE;
                fin        <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_pkt_rx.sv
// Bench for uart_pkt_rx: random and directed frames, scoreboard of expected writes and frame events.
module tb_uart_pkt_rx;
    localparam int CPB = 8;
    localparam int WB  = 4;
    localparam int TO  = 400;
`ifdef UART_PKT_CHKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        uart_rx = 1'b1;
    logic        wr_ready = 1'b0;
    logic        wr_valid, frame_done, err_valid, busy;
    logic [1:0]  wr_tgt;
    logic [15:0] wr_addr;
    logic [31:0] wr_data;
    logic [2:0]  err_code;

    uart_pkt_rx #(
        .CLK_HZ(80), .BAUD(10), .WORD_BYTES(WB), .ADDR_W(16), .TIMEOUT_CLKS(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_tgt(wr_tgt),
        .wr_addr(wr_addr), .wr_data(wr_data), .frame_done(frame_done),
        .err_valid(err_valid), .err_code(err_code), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  tgt;
        logic [15:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_wr[$];
    int  exp_ev[$];   // 0 = frame_done, otherwise the expected err_code
    int  checks = 0;
    int  failures = 0;
    int  ready_mode = 1;   // 0 = hold low, 1 = hold high, 2 = random

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Sink ready, changed just after the rising edge
    initial forever begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       wr_ready = 1'b0;
            1:       wr_ready = 1'b1;
            default: wr_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Monitor: pops the scoreboard on every handshake and every frame event
    initial begin
        wr_t e;
        int  ev;
        logic [2:0] got;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (wr_valid && wr_ready) begin
                    if (exp_wr.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected", wr_addr, wr_data);
                    end else begin
                        e = exp_wr.pop_front();
                        check("wr_tgt", 64'(wr_tgt), 64'(e.tgt));
                        check("wr_addr", 64'(wr_addr), 64'(e.addr));
                        check("wr_data", 64'(wr_data), 64'(e.data));
                    end
                end
                if (frame_done && err_valid) begin
                    checks++; failures++;
                    $display("FAIL done_and_err: both pulsed, err_code %0d", err_code);
                end
                if (frame_done || err_valid) begin
                    got = err_valid ? err_code : 3'd0;
                    if (exp_ev.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_event: got %0d (0=done), none expected", got);
                    end else begin
                        ev = exp_ev.pop_front();
                        check("frame_event", 64'(got), 64'(ev));
                    end
                end
            end
        end
    end

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: bench did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat ($urandom_range(1, 12)) @(negedge clk);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_wr.size() != 0 || exp_ev.size() != 0) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (exp_wr.size() != 0 || exp_ev.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d writes and %0d events still expected after %0d cycles",
                     exp_wr.size(), exp_ev.size(), n);
            exp_wr.delete();
            exp_ev.delete();
        end
        repeat (5) @(negedge clk);
    endtask

    // Reference model: decode a frame byte list into expected writes and the final event
    task automatic model(input logic [7:0] fr[$], output int nsend);
        wr_t w;
        int len;
        logic [15:0] base;
        logic [7:0] x;
        if (fr[1] < 8'd1 || fr[1] > 8'd3) begin
            exp_ev.push_back(2);
            nsend = 2;
            return;
        end
        len = int'(fr[4]);
        if (len == 0) begin
            exp_ev.push_back(3);
            nsend = 5;
            return;
        end
        base = {fr[3], fr[2]};
        for (int k = 0; k < len; k++) begin
            w.tgt  = 2'(fr[1] - 8'd1);
            w.addr = base + 16'(k);
            for (int j = 0; j < WB; j++) w.data[8*j +: 8] = fr[5 + WB*k + j];
            exp_wr.push_back(w);
        end
        nsend = fr.size();
        if (CHK_EN) begin
            x = 8'h00;
            for (int i = 1; i < nsend - 1; i++) x ^= fr[i];
            exp_ev.push_back((x == fr[nsend-1]) ? 0 : 6);
        end else begin
            exp_ev.push_back(0);
        end
    endtask

    task automatic run_frame(input logic [7:0] cmd, input logic [15:0] addr, input logic [7:0] len,
                             input bit fixed, input bit corrupt);
        logic [7:0] fr[$];
        logic [7:0] x;
        int nsend;
        fr.push_back(8'hA5);
        fr.push_back(cmd);
        fr.push_back(addr[7:0]);
        fr.push_back(addr[15:8]);
        fr.push_back(len);
        for (int i = 0; i < int'(len) * WB; i++)
            fr.push_back(fixed ? 8'(8'h11 * (i + 1)) : 8'($urandom));
        x = 8'h00;
        for (int i = 1; i < fr.size(); i++) x ^= fr[i];
        if (CHK_EN) fr.push_back(corrupt ? ~x : x);
        model(fr, nsend);
        for (int i = 0; i < nsend; i++) send_byte(fr[i], 1'b1);
        wait_drain();
    endtask

    initial begin
        logic [7:0] nb;
        logic [7:0] ovr[$];

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_wr_valid", 64'(wr_valid), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_err_valid", 64'(err_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err_code", 64'(err_code), 64'd0);
        check("rst_wr_addr", 64'(wr_addr), 64'd0);
        check("rst_wr_data", 64'(wr_data), 64'd0);
        check("rst_wr_tgt", 64'(wr_tgt), 64'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Reference frame: two words to buffer A
        ready_mode = 1;
        run_frame(8'h02, 16'h0010, 8'd2, 1'b1, 1'b0);
        check("idle_busy", 64'(busy), 64'd0);

        // Overrun with the sink stalled
        ready_mode = 0;
        ovr = '{8'hA5, 8'h02, 8'h10, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44};
        foreach (ovr[i]) send_byte(ovr[i], 1'b1);
        repeat (3) @(negedge clk);
        check("ovr_pending_valid", 64'(wr_valid), 64'd1);
        check("ovr_pending_addr", 64'(wr_addr), 64'h0010);
        check("ovr_pending_data", 64'(wr_data), 64'h44332211);
        check("ovr_pending_tgt", 64'(wr_tgt), 64'd1);
        exp_ev.push_back(4);
        send_byte(8'h55, 1'b1); send_byte(8'h66, 1'b1);
        send_byte(8'h77, 1'b1); send_byte(8'h88, 1'b1);
        wait_drain();
        check("ovr_dropped_valid", 64'(wr_valid), 64'd0);
        ready_mode = 1;

        // Bad command then a good frame
        run_frame(8'h07, 16'h1234, 8'd1, 1'b0, 1'b0);
        run_frame(8'h03, 16'h0200, 8'd1, 1'b0, 1'b0);

        // Zero length, address wrap
        run_frame(8'h01, 16'h0040, 8'd0, 1'b0, 1'b0);
        run_frame(8'h01, 16'hFFFF, 8'd2, 1'b0, 1'b0);

        // Stop bit low on the first payload byte
        exp_ev.push_back(1);
        send_byte(8'hA5, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h20, 1'b1);
        send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h5A, 1'b0);
        wait_drain();

        // Line idle after CMD
        exp_ev.push_back(5);
        send_byte(8'hA5, 1'b1); send_byte(8'h01, 1'b1);
        wait_drain();

        // Corrupted checksum (a plain good frame when checksums are off)
        run_frame(8'h02, 16'h0300, 8'd2, 1'b0, 1'b1);

        // Reset in the middle of the payload
        send_byte(8'hA5, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'h10, 1'b1);
        send_byte(8'h00, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        check("mid_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_rst_wr_valid", 64'(wr_valid), 64'd0);
        check("mid_rst_err_valid", 64'(err_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_err_code", 64'(err_code), 64'd0);
        check("mid_rst_wr_addr", 64'(wr_addr), 64'd0);
        check("mid_rst_wr_data", 64'(wr_data), 64'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        run_frame(8'h01, 16'h0500, 8'd1, 1'b0, 1'b0);

        // Random frames with idle noise and a random sink
        ready_mode = 2;
        for (int f = 0; f < 10; f++) begin
            nb = 8'($urandom);
            if (nb == 8'hA5) nb = 8'h00;
            send_byte(nb, 1'b1);
            run_frame(8'($urandom_range(0, 4)), 16'($urandom), 8'($urandom_range(0, 3)),
                      1'b0, ($urandom_range(0, 3) == 0));
        end
        ready_mode = 1;
        repeat (20) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
